// File: rtl/upf_demo.sv
// Power-managed accumulator with two domains. The core accumulator loses its state while OFF.
// The always-on FSM saves it to a retention register before power-down and restores it on power-up.
module upf_demo #(
  parameter int unsigned PWRUP_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] in,
  input  logic       en,
  input  logic       mode,
  input  logic       mode_req,
  output logic       mode_ack,
  output logic [7:0] out
);

  typedef enum logic [2:0] {
    RUN,
    ISO,
    SAVE,
    OFF,
    PWRUP,
    RESTORE,
    DEISO
  } state_t;

  localparam logic [3:0] LAST_CNT = 4'(PWRUP_CYCLES - 1);

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_acc;
  logic [7:0] r_ret;
  logic [7:0] r_out;
  logic       r_ack;
  logic [3:0] r_cnt;
  logic       w_pwrupDone;
  logic       w_redundant;
  logic [7:0] w_sum;

  assign w_pwrupDone = (r_cnt == LAST_CNT);
  assign w_sum       = r_acc + in;
  assign w_redundant = mode_req && (((r_state == RUN) && mode) || ((r_state == OFF) && !mode));
  assign mode_ack    = r_ack;
  assign out         = r_out;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= RUN;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      RUN:     if (mode_req && !mode) w_next = ISO;
      ISO:     w_next = SAVE;
      SAVE:    w_next = OFF;
      OFF:     if (mode_req && mode) w_next = PWRUP;
      PWRUP:   if (w_pwrupDone) w_next = RESTORE;
      RESTORE: w_next = DEISO;
      DEISO:   w_next = RUN;
      default: w_next = RUN;
    endcase
  end

  // The settle counter restarts from zero whenever PWRUP is not the current state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                             r_cnt <= '0;
    else if ((r_state == PWRUP) && !w_pwrupDone) r_cnt <= r_cnt + 4'd1;
    else                                      r_cnt <= '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc <= '0;
      r_ret <= '0;
      r_out <= '0;
      r_ack <= 1'b0;
    end else begin
      r_ack <= w_redundant || (r_state == SAVE) || (r_state == DEISO);
      unique case (r_state)
        RUN: begin
          if (en) begin
            r_acc <= w_sum;
            r_out <= w_sum;
          end
        end
        // Leaving SAVE is the moment the core loses power, so its state is retained and cleared together.
        SAVE: begin
          r_ret <= r_acc;
          r_acc <= '0;
        end
        OFF:     if (en) r_out <= in;
        RESTORE: r_acc <= r_ret;
        DEISO:   r_out <= r_acc;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_upf_demo.sv
// Randomized self-checking bench for upf_demo. It runs directed scenarios first and then random traffic.
// A transaction-level model tracks the power mode and counts down the cycles left in each transition.
module tb_upf_demo;

  localparam int PWRUP = 2;

  logic       clk;
  logic       resetN;
  logic [7:0] dataIn;
  logic       en;
  logic       mode;
  logic       modeReq;
  logic       modeAck;
  logic [7:0] dataOut;

  int checkCount = 0;
  int passCount  = 0;

  bit         mFull;
  bit         mGoingUp;
  int         mBusy;
  logic [7:0] mAcc;
  logic [7:0] mRet;
  logic [7:0] mOut;
  bit         mAck;

  upf_demo #(.PWRUP_CYCLES(PWRUP)) dut (
    .clk     (clk),
    .reset_n (resetN),
    .in      (dataIn),
    .en      (en),
    .mode    (mode),
    .mode_req(modeReq),
    .mode_ack(modeAck),
    .out     (dataOut)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
  endtask

  task automatic modelReset();
    mFull    = 1'b1;
    mGoingUp = 1'b0;
    mBusy    = 0;
    mAcc     = '0;
    mRet     = '0;
    mOut     = '0;
    mAck     = 1'b0;
  endtask

  // One clock edge. A mode change is accepted only when no transition is in progress.
  task automatic modelStep(input bit e, input logic [7:0] d, input bit r, input bit m);
    mAck = 1'b0;
    if (mBusy > 0) begin
      mBusy--;
      if (mBusy == 0) begin
        mAck = 1'b1;
        if (mGoingUp) begin
          mFull = 1'b1;
          mAcc  = mRet;
          mOut  = mRet;
        end else begin
          mFull = 1'b0;
          mAcc  = '0;
        end
      end
    end else begin
      if (e) begin
        if (mFull) begin
          mAcc = mAcc + d;
          mOut = mAcc;
        end else begin
          mOut = d;
        end
      end
      if (r) begin
        if (m == mFull) mAck = 1'b1;
        else if (mFull) begin
          mRet     = mAcc;
          mGoingUp = 1'b0;
          mBusy    = 2;
        end else begin
          mGoingUp = 1'b1;
          mBusy    = PWRUP + 2;
        end
      end
    end
  endtask

  task automatic applyStimulus(input bit e, input logic [7:0] d, input bit r, input bit m, input string tag);
    en      = e;
    dataIn  = d;
    modeReq = r;
    mode    = m;
    @(posedge clk);
    modelStep(e, d, r, m);
    #1;
    checkOutput({tag, ".out"}, dataOut, mOut);
    checkOutput({tag, ".ack"}, {7'b0, modeAck}, {7'b0, mAck});
  endtask

  // Asserts reset between edges, checks the asynchronous clear, and releases reset before the next edge.
  task automatic pulseReset(input string tag);
    resetN = 1'b0;
    #1;
    modelReset();
    checkOutput({tag, ".out"}, dataOut, 8'd0);
    checkOutput({tag, ".ack"}, {7'b0, modeAck}, 8'd0);
    #1;
    resetN = 1'b1;
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, tag);
  endtask

  initial begin
    resetN  = 1'b0;
    en      = 1'b0;
    dataIn  = '0;
    mode    = 1'b1;
    modeReq = 1'b0;
    modelReset();
    #2;
    checkOutput("reset.out", dataOut, 8'd0);
    checkOutput("reset.ack", {7'b0, modeAck}, 8'd0);
    #10;
    resetN = 1'b1;

    applyStimulus(1'b1, 8'd1, 1'b0, 1'b0, "acc1");
    checkOutput("acc1.const", dataOut, 8'd1);
    applyStimulus(1'b1, 8'd2, 1'b0, 1'b0, "acc2");
    checkOutput("acc2.const", dataOut, 8'd3);

    applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, "down.req");
    idle(1, "down.save");
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, "down.off");
    checkOutput("down.ackConst", {7'b0, modeAck}, 8'd1);
    idle(1, "off.idle");

    applyStimulus(1'b1, 8'd1, 1'b0, 1'b0, "pass1");
    applyStimulus(1'b1, 8'd2, 1'b0, 1'b0, "pass2");
    checkOutput("pass2.const", dataOut, 8'd2);

    applyStimulus(1'b0, 8'd0, 1'b1, 1'b1, "up.req");
    idle(3, "up.wait");
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, "up.run");
    checkOutput("up.outConst", dataOut, 8'd3);
    checkOutput("up.ackConst", {7'b0, modeAck}, 8'd1);
    applyStimulus(1'b1, 8'd4, 1'b0, 1'b0, "restored");
    checkOutput("restored.const", dataOut, 8'd7);

    applyStimulus(1'b0, 8'd0, 1'b1, 1'b1, "redundant");
    checkOutput("redundant.ackConst", {7'b0, modeAck}, 8'd1);
    idle(1, "redundant.after");
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, "down2.req");
    idle(3, "down2.wait");
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b1, "up2.req");
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, "up2.ignoreLow");
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b1, "up2.ignoreHigh");
    idle(3, "up2.wait");

    applyStimulus(1'b1, 8'd243, 1'b0, 1'b0, "to250");
    applyStimulus(1'b1, 8'd10, 1'b0, 1'b0, "wrap");
    checkOutput("wrap.const", dataOut, 8'd4);

    applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, "abort.req");
    idle(1, "abort.save");
    pulseReset("abort.reset");
    applyStimulus(1'b1, 8'd0, 1'b0, 1'b0, "abort.acc");
    checkOutput("abort.accConst", dataOut, 8'd0);
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, "abort.down");
    idle(3, "abort.off");
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b1, "abort.up");
    idle(5, "abort.run");
    checkOutput("abort.retConst", dataOut, 8'd0);

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 49) == 0) pulseReset("rand.reset");
      applyStimulus(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 3) == 0),
                    1'($urandom_range(0, 1)), "rand");
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
